// File: rtl/myo_spi_scheduler_if.sv
// SPI-side handshake between the transaction scheduler and the shared SPI master.
// The scheduler owns the slave selects and the start strobe; the SPI master returns done.
interface myo_spi_scheduler_if #(
    parameter int unsigned NUM_MOTORS = 8
);
    logic                  spi_start;
    logic                  spi_done;
    logic [NUM_MOTORS-1:0] ss_n_o;

    modport master (
        output spi_start,
        output ss_n_o,
        input  spi_done
    );

    modport slave (
        input  spi_start,
        input  ss_n_o,
        output spi_done
    );
endinterface

// File: rtl/myo_spi_scheduler.sv
// Round-robin transaction scheduler for the shared myocontrol SPI bus.
// Each period tick sweeps the snapshotted enable mask in ascending order: select the unit,
// pulse spi_start, wait for spi_done or timeout, then release the bus for a gap.
module myo_spi_scheduler #(
    parameter int unsigned NUM_MOTORS     = 8,
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_MOTORS-1:0]         enable_mask,
    input  logic [31:0]                   period,
    input  logic                          clear_flags,
    myo_spi_scheduler_if.master           spi,
    output logic [$clog2(NUM_MOTORS)-1:0] motor_index,
    output logic                          xfer_valid,
    output logic                          cycle_done,
    output logic                          busy,
    output logic [NUM_MOTORS-1:0]         timeout_flags,
    output logic                          overrun
);
    localparam int unsigned IDX_W = $clog2(NUM_MOTORS);
    localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYCLES - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
    // Only meaningful when GAP_CYCLES >= 2; guarded at the use site.
    localparam logic [31:0] GAP_PENULT = 32'(GAP_CYCLES - 2);
    localparam logic [31:0] WAIT_LAST  = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStart,
        StWait,
        StGap
    } state_e;

    state_e                state_q;
    logic [NUM_MOTORS-1:0] snap_q;
    logic [31:0]           step_cnt_q;
    logic [31:0]           per_cnt_q;
    logic                  tick;

    logic [IDX_W-1:0]      first_idx;
    logic [IDX_W-1:0]      next_idx;
    logic                  next_valid;
    logic [NUM_MOTORS-1:0] first_sel_n;
    logic [NUM_MOTORS-1:0] next_sel_n;

    // Free-running period counter; a shortened period wraps at once if already past the end.
    always_ff @(posedge clock) begin
        if (reset || period == 32'd0) begin
            per_cnt_q <= '0;
        end else if (per_cnt_q >= period - 32'd1) begin
            per_cnt_q <= '0;
        end else begin
            per_cnt_q <= per_cnt_q + 32'd1;
        end
    end

    assign tick = (period != 32'd0) && (per_cnt_q == period - 32'd1);

    // Lowest enabled unit for a new sweep, and next higher unit in the current snapshot.
    always_comb begin
        first_idx  = '0;
        next_idx   = '0;
        next_valid = 1'b0;
        for (int i = int'(NUM_MOTORS) - 1; i >= 0; i--) begin
            if (enable_mask[i]) begin
                first_idx = IDX_W'(i);
            end
            if (snap_q[i] && (i > int'(motor_index))) begin
                next_idx   = IDX_W'(i);
                next_valid = 1'b1;
            end
        end
        first_sel_n            = '1;
        first_sel_n[first_idx] = 1'b0;
        next_sel_n             = '1;
        next_sel_n[next_idx]   = 1'b0;
    end

    // Sweep FSM with registered outputs; flag sets are written after clears so a set wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            snap_q        <= '0;
            step_cnt_q    <= '0;
            spi.ss_n_o    <= '1;
            spi.spi_start <= 1'b0;
            motor_index   <= '0;
            xfer_valid    <= 1'b0;
            cycle_done    <= 1'b0;
            busy          <= 1'b0;
            timeout_flags <= '0;
            overrun       <= 1'b0;
        end else begin
            spi.spi_start <= 1'b0;
            xfer_valid    <= 1'b0;
            cycle_done    <= 1'b0;

            if (clear_flags) begin
                timeout_flags <= '0;
                overrun       <= 1'b0;
            end
            if (tick && state_q != StIdle) begin
                overrun <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (tick && enable_mask != '0) begin
                        snap_q      <= enable_mask;
                        motor_index <= first_idx;
                        spi.ss_n_o  <= first_sel_n;
                        step_cnt_q  <= '0;
                        busy        <= 1'b1;
                        state_q     <= StSetup;
                    end
                end
                StSetup: begin
                    if (step_cnt_q == SETUP_LAST) begin
                        spi.spi_start <= 1'b1;
                        state_q       <= StStart;
                    end else begin
                        step_cnt_q <= step_cnt_q + 32'd1;
                    end
                end
                StStart: begin
                    step_cnt_q <= '0;
                    state_q    <= StWait;
                end
                StWait: begin
                    if (spi.spi_done || step_cnt_q == WAIT_LAST) begin
                        if (spi.spi_done) begin
                            xfer_valid <= 1'b1;
                        end else begin
                            timeout_flags[motor_index] <= 1'b1;
                        end
                        spi.ss_n_o <= '1;
                        step_cnt_q <= '0;
                        // A one-cycle gap is also its last cycle.
                        cycle_done <= (GAP_CYCLES == 1) && !next_valid;
                        state_q    <= StGap;
                    end else begin
                        step_cnt_q <= step_cnt_q + 32'd1;
                    end
                end
                StGap: begin
                    if (step_cnt_q == GAP_LAST) begin
                        step_cnt_q <= '0;
                        if (next_valid) begin
                            motor_index <= next_idx;
                            spi.ss_n_o  <= next_sel_n;
                            state_q     <= StSetup;
                        end else begin
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_q + 32'd1;
                        // cycle_done lands on the final gap cycle, one before busy drops.
                        if (GAP_CYCLES >= 2 && step_cnt_q == GAP_PENULT && !next_valid) begin
                            cycle_done <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_myo_spi_scheduler.sv
// Directed bench for myo_spi_scheduler: sweep timing, timeout, overrun, mid-sweep mask change,
// reset in WAIT and the stopped cases. A small SPI master model answers spi_start.
module tb_myo_spi_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  enable_mask;
    logic [31:0] period;
    logic        clear_flags;
    logic [2:0]  motor_index;
    logic        xfer_valid;
    logic        cycle_done;
    logic        busy;
    logic [7:0]  timeout_flags;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;

    myo_spi_scheduler_if #(.NUM_MOTORS(8)) bus ();

    myo_spi_scheduler dut (
        .clock         (clk),
        .reset         (reset),
        .enable_mask   (enable_mask),
        .period        (period),
        .clear_flags   (clear_flags),
        .spi           (bus),
        .motor_index   (motor_index),
        .xfer_valid    (xfer_valid),
        .cycle_done    (cycle_done),
        .busy          (busy),
        .timeout_flags (timeout_flags),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // SPI master model: done 10 cycles after the cycle in which spi_start is high.
    bit   model_en   = 1'b1;
    int   model_cd   = 0;
    logic model_done = 1'b0;
    logic stray_done = 1'b0;

    always @(posedge clk) begin
        if (bus.spi_start && model_en) begin
            model_cd   <= 9;
            model_done <= 1'b0;
        end else if (model_cd != 0) begin
            model_cd   <= model_cd - 1;
            model_done <= (model_cd == 1);
        end else begin
            model_done <= 1'b0;
        end
    end

    assign bus.spi_done = model_done | stray_done;

    // Event monitors, sampled mid-cycle.
    int n_start = 0;
    int n_xfer  = 0;
    int n_cd    = 0;
    int n_multi = 0;

    always @(negedge clk) begin
        if (bus.spi_start === 1'b1) n_start++;
        if (xfer_valid === 1'b1) n_xfer++;
        if (cycle_done === 1'b1) n_cd++;
        if ($countones(~bus.ss_n_o) > 1) n_multi++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ss_low(input int bound, input string tag);
        int k = 0;
        while (bus.ss_n_o === 8'hFF && k < bound) begin
            step(1);
            k++;
        end
        check(tag, 32'(k < bound), 32'd1);
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < bound) begin
            step(1);
            k++;
        end
        check(tag, 32'(k < bound), 32'd1);
    endtask

    int st0, x0, cd0;

    initial begin
        reset       = 1'b1;
        enable_mask = 8'h00;
        period      = 32'd0;
        clear_flags = 1'b0;
        step(2);

        // Reset state.
        check("rst_ss", bus.ss_n_o, 8'hFF);
        check("rst_start", bus.spi_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_xfer", xfer_valid, 1'b0);
        check("rst_cd", cycle_done, 1'b0);
        check("rst_idx", motor_index, 3'd0);
        check("rst_tflags", timeout_flags, 8'h00);
        check("rst_ovr", overrun, 1'b0);

        // Mask 0x05, period 200, 10-cycle transfers.
        period      = 32'd200;
        enable_mask = 8'h05;
        reset       = 1'b0;
        st0 = n_start; x0 = n_xfer; cd0 = n_cd;
        wait_ss_low(250, "m05_tick");          // cycle t+1
        check("m05_ss0", bus.ss_n_o, 8'hFE);
        check("m05_idx0", motor_index, 3'd0);
        check("m05_busy", busy, 1'b1);
        step(2);                               // t+3 = s
        check("m05_start0", bus.spi_start, 1'b1);
        step(1);
        check("m05_start0_off", bus.spi_start, 1'b0);
        step(9);                               // s+10
        check("m05_xv_early", xfer_valid, 1'b0);
        step(1);                               // s+11
        check("m05_xv0", xfer_valid, 1'b1);
        check("m05_xv0_idx", motor_index, 3'd0);
        check("m05_gap_ss", bus.ss_n_o, 8'hFF);
        step(4);                               // s+15
        check("m05_ss2", bus.ss_n_o, 8'hFB);
        check("m05_idx2", motor_index, 3'd2);
        step(13);                              // s+28
        check("m05_xv2", xfer_valid, 1'b1);
        check("m05_xv2_idx", motor_index, 3'd2);
        step(3);                               // s+31
        check("m05_cd", cycle_done, 1'b1);
        check("m05_cd_busy", busy, 1'b1);
        step(1);                               // s+32 = t+35
        check("m05_cd_off", cycle_done, 1'b0);
        check("m05_idle", busy, 1'b0);
        check("m05_nstart", 32'(n_start - st0), 32'd2);
        check("m05_nxfer", 32'(n_xfer - x0), 32'd2);
        check("m05_ncd", 32'(n_cd - cd0), 32'd1);
        step(165);                             // t+200
        check("m05_period_pre", bus.ss_n_o, 8'hFF);
        step(1);                               // t+201
        check("m05_period", bus.ss_n_o, 8'hFE);
        step(40);

        // Mask 0x80, no done: timeout.
        enable_mask = 8'h80;
        model_en    = 1'b0;
        x0 = n_xfer;
        wait_ss_low(300, "to_tick");
        check("to_ss", bus.ss_n_o, 8'h7F);
        check("to_idx", motor_index, 3'd7);
        step(2);                               // s
        check("to_start", bus.spi_start, 1'b1);
        step(4096);                            // s+4096
        check("to_ss_held", bus.ss_n_o, 8'h7F);
        check("to_flag_pre", timeout_flags, 8'h00);
        step(1);                               // s+4097
        check("to_ss_rel", bus.ss_n_o, 8'hFF);
        check("to_flag", timeout_flags, 8'h80);
        step(3);                               // s+4100
        check("to_cd", cycle_done, 1'b1);
        check("to_ovr", overrun, 1'b1);
        check("to_nxfer", 32'(n_xfer - x0), 32'd0);
        enable_mask = 8'h00;
        step(2);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        check("clr_tflags", timeout_flags, 8'h00);
        check("clr_ovr", overrun, 1'b0);

        // Mask 0xFF, period 50: sweeps longer than the period.
        model_en    = 1'b1;
        period      = 32'd50;
        enable_mask = 8'hFF;
        st0 = n_start; x0 = n_xfer; cd0 = n_cd;
        step(600);
        check("ovr_set", overrun, 1'b1);
        enable_mask = 8'h00;
        wait_idle(300, "ovr_drain");
        check("ovr_sweeps", 32'((n_cd - cd0) >= 3), 32'd1);
        check("ovr_xfer_per_sweep", 32'(n_xfer - x0), 32'(8 * (n_cd - cd0)));
        check("ovr_start_eq_xfer", 32'(n_start - st0), 32'(n_xfer - x0));

        // Mask 0x03 -> 0x0C during WAIT on unit 0.
        period = 32'd0;
        step(2);
        enable_mask = 8'h03;
        period      = 32'd500;
        x0 = n_xfer; cd0 = n_cd;
        wait_ss_low(600, "mc_tick");           // t+1
        check("mc_ss0", bus.ss_n_o, 8'hFE);
        step(3);                               // s+1, WAIT
        enable_mask = 8'h0C;
        step(10);                              // s+11
        check("mc_xv0", xfer_valid, 1'b1);
        step(4);                               // s+15
        check("mc_ss1", bus.ss_n_o, 8'hFD);
        check("mc_idx1", motor_index, 3'd1);
        step(16);                              // s+31
        check("mc_cd", cycle_done, 1'b1);
        check("mc_nxfer", 32'(n_xfer - x0), 32'd2);
        step(466);                             // t+500
        check("mc_next_pre", bus.ss_n_o, 8'hFF);
        step(1);                               // t+501
        check("mc_ss2", bus.ss_n_o, 8'hFB);
        check("mc_idx2", motor_index, 3'd2);
        step(17);
        check("mc_ss3", bus.ss_n_o, 8'hF7);
        check("mc_idx3", motor_index, 3'd3);

        // Reset while in WAIT on unit 3.
        step(3);
        check("rw_ss_pre", bus.ss_n_o, 8'hF7);
        check("rw_ovr_pre", overrun, 1'b1);
        reset = 1'b1;
        step(1);
        check("rw_ss", bus.ss_n_o, 8'hFF);
        check("rw_busy", busy, 1'b0);
        check("rw_ovr", overrun, 1'b0);
        check("rw_tflags", timeout_flags, 8'h00);
        check("rw_idx", motor_index, 3'd0);
        reset  = 1'b0;
        period = 32'd0;
        x0 = n_xfer;
        step(15);                              // model done arrives in here
        check("rw_no_xfer", 32'(n_xfer - x0), 32'd0);

        // Stopped scheduler: period 0, then mask 0.
        enable_mask = 8'hFF;
        st0 = n_start; x0 = n_xfer;
        step(500);
        stray_done = 1'b1;
        step(1);
        stray_done = 1'b0;
        step(499);
        check("p0_nstart", 32'(n_start - st0), 32'd0);
        check("p0_nxfer", 32'(n_xfer - x0), 32'd0);
        check("p0_ovr", overrun, 1'b0);
        enable_mask = 8'h00;
        period      = 32'd300;
        st0 = n_start;
        step(1000);
        check("m0_nstart", 32'(n_start - st0), 32'd0);
        check("m0_ovr", overrun, 1'b0);
        check("m0_busy", busy, 1'b0);

        check("one_ss_low", 32'(n_multi), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
